prefix_adder: RTL and testbench
===============================

// Module: prefix_adder
// PURPOSE
// - Parallel-prefix (Sklansky) carry-propagate adder: s/cout = a + b + cin, unsigned, full WIDTH.
// - Shared arithmetic primitive for the core datapath (ALU add/sub, address generation).
// - Default build is purely combinational; an optional output register is available via macro.
// PARAMETERS
// - WIDTH  32  operand/sum width in bits; must be a power of two, >= 2
// PORTS
// - clk    in   1      single clock; used only when PREFIX_ADDER_REG_OUT_EN is defined
// - rst_n  in   1      reset, synchronous, active-low
// - a      in   WIDTH  operand A
// - b      in   WIDTH  operand B
// - cin    in   1      carry in to bit 0
// - s      out  WIDTH  sum bits [WIDTH-1:0] of a+b+cin
// - cout   out  1      carry out of bit WIDTH-1
// BEHAVIOUR
// - Interface: one clock (clk); reset rst_n is synchronous and active-low.
// - {cout, s} == a + b + cin, evaluated in WIDTH+1 bits; no signed overflow flag.
// - Bit-level pre-processing: g[i] = a[i]&b[i], p[i] = a[i]^b[i].
// - cin folded in as prefix position -1: G[-1] = cin, P[-1] = 0.
// - Prefix tree: log2(WIDTH) Sklansky levels of black cells (G = Gh | Ph&Gl, P = Ph&Pl).
//   Gray cells are permitted where P is unused.
// - Post-processing: s[i] = p[i] ^ G[i-1:-1]; cout = G[WIDTH-1:-1].
// - Must not use the '+' operator in the datapath; the explicit prefix network is the deliverable.
// - Default (macro undefined): zero latency; s/cout settle combinationally from a/b/cin.
//   clk and rst_n are unused; rst_n has no effect.
// - No X-propagation masking: X on inputs may propagate to outputs.
// - Boundary cases:
//   - all-ones + 0 + cin=1 -> s=0, cout=1 (full ripple through the tree);
//   - 0+0+0 -> s=0, cout=0;
//   - all-ones + all-ones + 1 -> s=all-ones, cout=1.
// CONFIGURATION
// - Macro PREFIX_ADDER_REG_OUT_EN:
//   - Defined: s and cout are registered on posedge clk, 1-cycle latency.
//   - rst_n==0 at a posedge sets s=0, cout=0; reset wins over new operands in the same cycle.
//   - First valid result appears on the first posedge after rst_n returns high.
//   - Undefined: purely combinational as described above.
// STRUCTURE
// - Package prefix_adder_pkg:
//   - localparam int DEFAULT_WIDTH = 32;
//   - function clog2-based LEVELS(WIDTH);
//   - typedef struct packed {logic g; logic p;} gp_t.
// - Sub-module prefix_black_cell: inputs (gh, ph, gl, pl), outputs (g, p), purely combinational.
// - Top: generate loops over levels/bits instantiating prefix_black_cell.
//   Static WIDTH check: $error at elaboration if not a power of two.
// TESTING (WIDTH=32, combinational build, check 10 time units after input change)
// - a=0000_0000 b=0000_0000 cin=0 -> s=0000_0000 cout=0
// - a=FFFF_FFFF b=0000_0000 cin=1 -> s=0000_0000 cout=1 (longest carry chain)
// - a=FFFF_FFFF b=FFFF_FFFF cin=1 -> s=FFFF_FFFF cout=1
// - a=1234_5678 b=8765_4321 cin=0 -> s=9999_9999 cout=0
// - a=8000_0000 b=8000_0000 cin=0 -> s=0000_0000 cout=1; then 10k random vectors vs a+b+cin golden
// - Registered build: apply a=1,b=1,cin=1 with rst_n=0 -> s=0 cout=0.
//   Release rst_n -> next posedge s=0000_0003 cout=0.

Source files
------------

// File: rtl/prefix_adder_pkg.sv
// ----------------------------------------------------------------------------
// prefix_adder_pkg
// Shared definitions for the Sklansky parallel-prefix adder.
//   DEFAULT_WIDTH : default operand width (power of two)
//   LEVELS()      : number of prefix-tree levels for a given width
//   gp_t          : generate/propagate pair carried through the tree
// ----------------------------------------------------------------------------
package prefix_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Sklansky needs one level per doubling of the span: log2(width).
    function automatic int LEVELS(input int width);
        return $clog2(width);
    endfunction

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/prefix_black_cell.sv
// ----------------------------------------------------------------------------
// prefix_black_cell
// Combines a high (more significant) group with the adjacent low group.
// Ports:
//   gh, ph : generate / propagate of the high group
//   gl, pl : generate / propagate of the low group
//   g, p   : generate / propagate of the merged group
// Purely combinational.
// ----------------------------------------------------------------------------
module prefix_black_cell (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    assign g = gh | (ph & gl);
    assign p = ph & pl;

endmodule

// File: rtl/prefix_adder.sv
// ----------------------------------------------------------------------------
// prefix_adder
// Sklansky parallel-prefix carry-propagate adder: {cout, s} = a + b + cin.
// Parameters:
//   WIDTH : operand/sum width; power of two, >= 2
// Ports:
//   clk   : clock, only used when PREFIX_ADDER_REG_OUT_EN is defined
//   rst_n : synchronous active-low reset, only used with the output register
//   a, b  : operands
//   cin   : carry into bit 0
//   s     : sum bits
//   cout  : carry out of the top bit
// Configuration macro:
//   PREFIX_ADDER_REG_OUT_EN : when defined, s/cout are registered (1 cycle
//                             latency); otherwise the adder is combinational.
// ----------------------------------------------------------------------------
module prefix_adder
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int NUM_LEVELS = LEVELS(WIDTH);

    if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_width_check
        $error("prefix_adder: WIDTH (%0d) must be a power of two >= 2", WIDTH);
    end

    // Bit-level generate/propagate.
    gp_t  [WIDTH-1:0] gp_bit;
    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pre
        assign gp_bit[i].g = a[i] & b[i];
        assign gp_bit[i].p = a[i] ^ b[i];
        assign g_bit[i]    = gp_bit[i].g;
        assign p_bit[i]    = gp_bit[i].p;
    end

    // Sklansky tree. At level l, every bit whose index has bit l set merges
    // with the top bit of the lower half of its 2^(l+1) block, which already
    // holds the complete prefix of that half. After the last level each bit
    // holds the group G/P over [i:0].
    for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_level
        logic [WIDTH-1:0] g_in;
        logic [WIDTH-1:0] p_in;
        logic [WIDTH-1:0] g_out;
        logic [WIDTH-1:0] p_out;

        if (l == 0) begin : g_first
            assign g_in = g_bit;
            assign p_in = p_bit;
        end else begin : g_chain
            assign g_in = g_level[l-1].g_out;
            assign p_in = g_level[l-1].p_out;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (((i >> l) & 1) == 1) begin : g_cell
                localparam int J = ((i >> l) << l) - 1;
                prefix_black_cell u_cell (
                    .gh (g_in[i]),
                    .ph (p_in[i]),
                    .gl (g_in[J]),
                    .pl (p_in[J]),
                    .g  (g_out[i]),
                    .p  (p_out[i])
                );
            end else begin : g_pass
                assign g_out[i] = g_in[i];
                assign p_out[i] = p_in[i];
            end
        end
    end

    logic [WIDTH-1:0] grp_g;
    logic [WIDTH-1:0] grp_p;
    assign grp_g = g_level[NUM_LEVELS-1].g_out;
    assign grp_p = g_level[NUM_LEVELS-1].p_out;

    // Fold cin in as position -1 (G=cin, P=0): a gray cell per bit, since the
    // merged P would always be zero and is never needed.
    // carry[i] = G[i-1:-1]
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_comb;
    assign carry  = {grp_g | (grp_p & {WIDTH{cin}}), cin};
    assign s_comb = p_bit ^ carry[WIDTH-1:0];

`ifdef PREFIX_ADDER_REG_OUT_EN
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is checked first so it wins over operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= s_comb;
            cout <= carry[WIDTH];
        end
    end
`else
    assign s    = s_comb;
    assign cout = carry[WIDTH];

    // Clock and reset have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule

// File: tb/tb_prefix_adder.sv
// ----------------------------------------------------------------------------
// tb_prefix_adder
// Scoreboard bench for prefix_adder (WIDTH = 32). Stimulus pushes the expected
// {cout, s} into a queue; a monitor pops and compares whenever the output is
// due (10 time units after the inputs in the combinational build, #1 after
// the next posedge in the registered build).
// ----------------------------------------------------------------------------
module tb_prefix_adder;
    import prefix_adder_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;

    typedef struct {
        logic [W:0] exp;
        string      name;
    } exp_t;

    typedef struct {
        string      name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   exp;
    } vec_t;

    exp_t sb_q[$];
    event sample_ev;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    prefix_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout)
    );

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compares DUT output against the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: output sampled with no expected entry");
            end else begin
                e = sb_q.pop_front();
                check(e.name, {cout, s}, e.exp);
            end
        end
    end

    task automatic apply(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vcin, input logic [W:0] exp);
        exp_t e;
        a   = va;
        b   = vb;
        cin = vcin;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
`ifdef PREFIX_ADDER_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #10;
`endif
        -> sample_ev;
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   gold;

        a = '0; b = '0; cin = 1'b0;
        rst_n = 1'b0;
        #2;

        // Reset behaviour: registered build clears, combinational build ignores rst_n.
`ifdef PREFIX_ADDER_REG_OUT_EN
        apply("reset_clears", 32'h0000_0001, 32'h0000_0001, 1'b1, 33'h0_0000_0000);
`else
        apply("reset_no_effect", 32'h0000_0001, 32'h0000_0001, 1'b1, 33'h0_0000_0003);
`endif
        rst_n = 1'b1;
        apply("first_after_reset", 32'h0000_0001, 32'h0000_0001, 1'b1, 33'h0_0000_0003);

        vecs.push_back('{"zero",        32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000});
        vecs.push_back('{"long_chain",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000});
        vecs.push_back('{"ones_ones_1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF});
        vecs.push_back('{"mixed",       32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999});
        vecs.push_back('{"msb_carry",   32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000});
        vecs.push_back('{"ones_no_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33'h0_FFFF_FFFF});
        vecs.push_back('{"cin_only",    32'h0000_0000, 32'h0000_0000, 1'b1, 33'h0_0000_0001});
        vecs.push_back('{"alt_bits",    32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000});
        vecs.push_back('{"half_carry",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 33'h0_0001_0000});
        vecs.push_back('{"ones_ones_0", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE});
        vecs.push_back('{"byte_carry",  32'h00FF_00FF, 32'h0001_0001, 1'b0, 33'h0_0100_0100});

        foreach (vecs[k]) apply(vecs[k].name, vecs[k].a, vecs[k].b, vecs[k].cin, vecs[k].exp);

        for (int n = 0; n < 10000; n++) begin
            ra   = $urandom;
            rb   = $urandom;
            rc   = 1'($urandom_range(1, 0));
            gold = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            apply("random", ra, rb, rc, gold);
        end

        #20;
        check("sb_drain", (W+1)'(sb_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
